// File: rtl/crc_serial_engine.sv
// Serial CRC engine: absorbs one message bit per clock while active is high,
// then shifts the final CRC out MSB-first with a valid window and a done pulse.
module crc_serial_engine #(
  parameter int          CRC_WIDTH = 8,
  parameter logic [31:0] POLY      = 32'h0000_0007,
  parameter logic [31:0] SEED      = 32'h0000_0000,
  parameter logic [31:0] XOROUT    = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 active,
  input  logic                 data_in,
  output logic                 crc_out,
  output logic                 valid,
  output logic [CRC_WIDTH-1:0] crc_par,
  output logic                 done
);

  localparam int CNT_W = $clog2(CRC_WIDTH + 1);
  localparam logic [CRC_WIDTH-1:0] P_POLY   = POLY[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] P_SEED   = SEED[CRC_WIDTH-1:0];
  localparam logic [CRC_WIDTH-1:0] P_XOROUT = XOROUT[CRC_WIDTH-1:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t               r_state, r_state_next;
  logic [CRC_WIDTH-1:0] r_lfsr, r_lfsr_next;
  logic [CRC_WIDTH-1:0] r_out_sr, r_out_sr_next;
  logic [CRC_WIDTH-1:0] r_crc_par, r_crc_par_next;
  logic [CNT_W-1:0]     r_cnt, r_cnt_next;
  logic                 r_crc_out, r_crc_out_next;
  logic                 r_valid, r_valid_next;
  logic                 r_done, r_done_next;
  logic                 r_active_prev;

  logic                 w_start;
  logic [CRC_WIDTH-1:0] w_final;

  function automatic logic [CRC_WIDTH-1:0] f_step(input logic [CRC_WIDTH-1:0] s,
                                                  input logic b);
    logic fb;
    fb = b ^ s[CRC_WIDTH-1];
    return {s[CRC_WIDTH-2:0], 1'b0} ^ (fb ? P_POLY : '0);
  endfunction

  // A rising edge of active restarts the engine from any state, aborting output.
  assign w_start = active & ~r_active_prev;
  assign w_final = r_lfsr ^ P_XOROUT;

  always_comb begin
    r_state_next   = r_state;
    r_lfsr_next    = r_lfsr;
    r_out_sr_next  = r_out_sr;
    r_crc_par_next = r_crc_par;
    r_cnt_next     = r_cnt;
    r_crc_out_next = r_crc_out;
    r_valid_next   = r_valid;
    r_done_next    = r_done;
    if (w_start) begin
      r_lfsr_next  = f_step(P_SEED, data_in);
      r_state_next = SHIFT;
      r_valid_next = 1'b0;
      r_done_next  = 1'b0;
    end else begin
      case (r_state)
        SHIFT: begin
          if (active) begin
            r_lfsr_next = f_step(r_lfsr, data_in);
          end else begin
            r_crc_par_next = w_final;
            r_crc_out_next = w_final[CRC_WIDTH-1];
            r_out_sr_next  = {w_final[CRC_WIDTH-2:0], 1'b0};
            r_valid_next   = 1'b1;
            r_cnt_next     = CNT_W'(CRC_WIDTH - 1);
            r_state_next   = OUT;
          end
        end
        OUT: begin
          if (!active) begin
            if (r_cnt != '0) begin
              r_crc_out_next = r_out_sr[CRC_WIDTH-1];
              r_out_sr_next  = {r_out_sr[CRC_WIDTH-2:0], 1'b0};
              r_cnt_next     = r_cnt - CNT_W'(1);
              r_done_next    = (r_cnt == CNT_W'(1));
            end else begin
              r_valid_next   = 1'b0;
              r_done_next    = 1'b0;
              r_crc_out_next = 1'b0;
              r_state_next   = IDLE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_lfsr        <= P_SEED;
      r_out_sr      <= '0;
      r_crc_par     <= '0;
      r_cnt         <= '0;
      r_crc_out     <= 1'b0;
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
      r_active_prev <= 1'b0;
    end else begin
      r_state       <= r_state_next;
      r_lfsr        <= r_lfsr_next;
      r_out_sr      <= r_out_sr_next;
      r_crc_par     <= r_crc_par_next;
      r_cnt         <= r_cnt_next;
      r_crc_out     <= r_crc_out_next;
      r_valid       <= r_valid_next;
      r_done        <= r_done_next;
      r_active_prev <= active;
    end
  end

  assign crc_out = r_crc_out;
  assign valid   = r_valid;
  assign crc_par = r_crc_par;
  assign done    = r_done;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench: CRC-8 (0x07) and CRC-16/CCITT-FALSE instances share one stimulus stream.
module tb_crc_serial_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, active, data_in;
  logic crc_out8, valid8, done8;
  logic [7:0] par8;
  logic crc_out16, valid16, done16;
  logic [15:0] par16;

  int checks = 0;
  int errors = 0;

  crc_serial_engine dut8 (
    .clk(clk), .rst(rst), .active(active), .data_in(data_in),
    .crc_out(crc_out8), .valid(valid8), .crc_par(par8), .done(done8)
  );

  crc_serial_engine #(
    .CRC_WIDTH(16), .POLY(32'h0000_1021), .SEED(32'h0000_FFFF), .XOROUT(32'h0)
  ) dut16 (
    .clk(clk), .rst(rst), .active(active), .data_in(data_in),
    .crc_out(crc_out16), .valid(valid16), .crc_par(par16), .done(done16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      active  = 1'b1;
      data_in = b[i];
    end
  endtask

  // Drop active, then watch both serial windows and the trailing valid fall.
  task automatic collect(input string tag, input logic [7:0] exp8,
                         input bit use16, input logic [15:0] exp16);
    logic [7:0]  s8;
    logic [15:0] s16;
    s8  = '0;
    s16 = '0;
    @(negedge clk);
    active  = 1'b0;
    data_in = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      if (k < 8) begin
        s8 = {s8[6:0], crc_out8};
        chk({tag, " valid8"}, 32'(valid8), 32'd1);
        chk({tag, " done8"}, 32'(done8), (k == 7) ? 32'd1 : 32'd0);
      end else if (k == 8) begin
        chk({tag, " valid8_end"}, 32'(valid8), 32'd0);
      end
      if (use16) begin
        if (k < 16) begin
          s16 = {s16[14:0], crc_out16};
          chk({tag, " valid16"}, 32'(valid16), 32'd1);
          chk({tag, " done16"}, 32'(done16), (k == 15) ? 32'd1 : 32'd0);
        end else begin
          chk({tag, " valid16_end"}, 32'(valid16), 32'd0);
        end
      end
    end
    chk({tag, " serial8"}, 32'(s8), 32'(exp8));
    chk({tag, " par8"}, 32'(par8), 32'(exp8));
    if (use16) begin
      chk({tag, " serial16"}, 32'(s16), 32'(exp16));
      chk({tag, " par16"}, 32'(par16), 32'(exp16));
    end
    $display("msg %s: serial8=%02h par8=%02h serial16=%04h par16=%04h", tag, s8, par8, s16, par16);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] msg [9];
    logic [7:0] one;
    msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    one = 8'h01;

    rst = 1'b0; active = 1'b0; data_in = 1'b0;
    #12;
    chk("reset valid8", 32'(valid8), 32'd0);
    chk("reset crc_out8", 32'(crc_out8), 32'd0);
    chk("reset par8", 32'(par8), 32'd0);
    chk("reset done8", 32'(done8), 32'd0);
    chk("reset par16", 32'(par16), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle valid8", 32'(valid8), 32'd0);
    $display("reset released");

    // 0x01 -> 0x07
    send_byte(8'h01);
    collect("0x01", 8'h07, 1'b0, 16'h0);

    // 0xFF -> 0xF3
    send_byte(8'hFF);
    collect("0xFF", 8'hF3, 1'b0, 16'h0);

    // IDLE holds crc_par
    @(negedge clk);
    chk("idle hold par8", 32'(par8), 32'hF3);
    chk("idle hold valid8", 32'(valid8), 32'd0);

    // "123456789" on both widths
    for (int i = 0; i < 9; i++) send_byte(msg[i]);
    collect("123456789", 8'hF4, 1'b1, 16'h29B1);

    // Abort after 3rd CRC bit
    send_byte(8'h01);
    @(negedge clk);
    active = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort pre valid8", 32'(valid8), 32'd1);
      chk("abort pre bit", 32'(crc_out8), 32'd0);
    end
    active  = 1'b1;
    data_in = one[7];
    for (int i = 6; i >= 0; i--) begin
      @(negedge clk);
      chk("abort valid8", 32'(valid8), 32'd0);
      chk("abort done8", 32'(done8), 32'd0);
      active  = 1'b1;
      data_in = one[i];
    end
    chk("abort par8 kept", 32'(par8), 32'h07);
    $display("abort: output window cut after 3 bits");
    collect("after-abort 0x01", 8'h07, 1'b0, 16'h0);

    // Single-cycle message of one '1' bit
    @(negedge clk);
    active  = 1'b1;
    data_in = 1'b1;
    collect("1-bit", 8'h07, 1'b0, 16'h0);

    // Async reset in the middle of the output window
    send_byte(8'hFF);
    @(negedge clk);
    active  = 1'b0;
    data_in = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk("pre-rst valid8", 32'(valid8), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst valid8", 32'(valid8), 32'd0);
    chk("midrst crc_out8", 32'(crc_out8), 32'd0);
    chk("midrst par8", 32'(par8), 32'd0);
    chk("midrst done8", 32'(done8), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post-rst valid8", 32'(valid8), 32'd0);
    end
    $display("mid-output reset applied");
    for (int i = 0; i < 9; i++) send_byte(msg[i]);
    collect("post-rst 123456789", 8'hF4, 1'b1, 16'h29B1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
